mem_responder: RTL and testbench

//   Memory-side responder for the CPU memory bus driven by the control unit's

---
 rtl/mem_responder.sv | 118 +++++++++++
 tb/tb_mem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// mem_responder: unified-RAM memory responder with req/ack handshake,
// fixed wait states and a side-load port for preloading before CPU release.
// Revision: 1.0
// ============================================================================
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam logic [3:0] c_wait_cycles = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  // Single RAM write port shared by store commit (end of RESP) and side load.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = load_addr;
    w_mem_wdata = load_data;
    if (r_state == ST_RESP && r_we) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_addr;
      w_mem_wdata = r_wdata;
    end else if (r_state == ST_IDLE && !req && load_en) begin
      w_mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      ack     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= '0;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= 4'd0;
            busy    <= 1'b1;
            if (c_wait_cycles == 4'd0) begin
              // No wait states: read straight from the live address.
              r_state <= ST_RESP;
              ack     <= 1'b1;
              if (!we) rdata <= r_mem[addr];
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt + 4'd1 == c_wait_cycles) begin
            r_state <= ST_RESP;
            ack     <= 1'b1;
            if (!r_we) rdata <= r_mem[r_addr];
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          ack     <= 1'b0;
          busy    <= 1'b0;
          r_cnt   <= 4'd0;
        end
        default: begin
          r_state <= ST_IDLE;
          ack     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_mem_responder: randomized scoreboard bench for mem_responder.
// Revision: 1.0
// ============================================================================
module tb_mem_responder;
  localparam int W = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       ack;
  logic       busy;
  logic       load_en = 1'b0;
  logic [7:0] load_addr = 8'h00;
  logic [7:0] load_data = 8'h00;

  mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [7:0] rd;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] model_mem [0:255];
  logic [7:0] model_rdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  // Monitor: every ack consumes one expected response.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got ack=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack_rdata", 32'(rdata), 32'(e.rd));
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        check("busy_in_ack", 32'(busy), 32'd1);
      end
    end
  end

  task automatic sload(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    model_mem[a] = d;
  endtask

  // mode 0: plain; 1: scramble addr/wdata mid-wait; 2: pulse load_en 0x30=0x77 mid-wait
  task automatic issue(input logic t_we, input logic [7:0] t_addr, input logic [7:0] t_data,
                       input int mode, input bit hold);
    logic [7:0] exp_r;
    int need, acks, busy_cnt;
    @(posedge clk); #1;
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_data;
    if (t_we) begin
      exp_r = model_rdata;
      model_mem[t_addr] = t_data;
    end else begin
      exp_r = model_mem[t_addr];
      model_rdata = exp_r;
    end
    exp_q.push_back(exp_t'{cyc + W + 1, exp_r});
    need = 1;
    if (hold) begin
      // Repeat is captured in the IDLE cycle after the first ack.
      exp_q.push_back(exp_t'{cyc + 2*W + 3, exp_r});
      need = 2;
    end
    acks = 0;
    busy_cnt = 0;
    for (int k = 0; k < 40 && acks < need; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (ack === 1'b1) acks++;
      if (k == 1 && mode == 1) begin
        addr = 8'hFF; wdata = 8'h00;
      end
      if (k == 1 && mode == 2) begin
        load_en = 1'b1; load_addr = 8'h30; load_data = 8'h77;
      end
      if (k == 2) load_en = 1'b0;
    end
    check("ack_count", 32'(acks), 32'(need));
    check("busy_cycles", 32'(busy_cnt), 32'(need * (W + 1)));
    @(posedge clk); #1;
    req = 1'b0; load_en = 1'b0;
    we = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
  endtask

  initial begin
    // Reset
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int a = 0; a < 256; a++) sload(8'(a), 8'($urandom));
    sload(8'h00, 8'hA5);
    sload(8'h01, 8'h3C);
    sload(8'h20, 8'h00);
    sload(8'h30, 8'h12);

    // Basic read, store with unchanged rdata, read-after-write
    issue(1'b0, 8'h01, 8'h00, 0, 1'b0);
    issue(1'b1, 8'h7F, 8'h5A, 0, 1'b0);
    issue(1'b0, 8'h7F, 8'h00, 0, 1'b0);

    // Inputs changing mid-wait must not matter
    issue(1'b1, 8'h10, 8'h11, 1, 1'b0);
    issue(1'b0, 8'h10, 8'h00, 0, 1'b0);
    issue(1'b0, 8'hFF, 8'h00, 0, 1'b0);

    // Reset in WAIT aborts a pending store
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 8'h99;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; req = 1'b0; model_rdata = 8'h00;
    @(negedge clk);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    issue(1'b0, 8'h20, 8'h00, 0, 1'b0);

    // Reset beats load_en while idle
    @(posedge clk); #1;
    reset = 1'b0; load_en = 1'b1; load_addr = 8'h21; load_data = ~model_mem[8'h21];
    @(posedge clk); #1;
    reset = 1'b1; load_en = 1'b0;
    issue(1'b0, 8'h21, 8'h00, 0, 1'b0);

    // load_en ignored while busy; held req repeats
    issue(1'b0, 8'h40, 8'h00, 2, 1'b0);
    issue(1'b0, 8'h30, 8'h00, 0, 1'b0);
    issue(1'b0, 8'h00, 8'h00, 0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2) sload(8'($urandom), 8'($urandom));
      else issue(1'($urandom), 8'($urandom), 8'($urandom), 0, r == 9);
    end

    repeat (5) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
